// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader and the instruction RAM.
// The arbiter takes the slave view; the environment (requesters plus RAM) takes the master view.
interface imem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 6
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;
  logic              fetch_err;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_idx, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates the single-ported instruction RAM between instruction fetch and the loader/debug port,
// with a starvation guard for the loader and a one-cycle response pipeline tagged by owner.
module imem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          boot_mode_i,
  imem_arbiter_if.slave bus
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_HI = ADDR_W - 1;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_FETCH_ERR,
    OWN_LOAD_RD
  } owner_e;

  owner_e           owner_q, ownerD;
  logic [CNT_W-1:0] starveCnt_q, starveCntD;
  logic             fetchRvalid_q, fetchErr_q, ldRvalid_q;
  logic [31:0]      fetchHold_q, ldHold_q;

  logic fetchGnt, ldGnt, starveHit, fetchAligned;
  logic unusedLdAddrLsb;

  assign unusedLdAddrLsb = ^bus.ld_addr[1:0];
  assign fetchAligned    = (bus.fetch_addr[1:0] == 2'b00);
  assign starveHit       = (starveCnt_q == CNT_W'(STARVE_MAX));

  // Fetch normally wins a collision; a loader that has lost STARVE_MAX times in a row takes the slot.
  always_comb begin
    fetchGnt = 1'b0;
    ldGnt    = 1'b0;
    if (boot_mode_i) begin
      ldGnt = bus.ld_req;
    end else if (bus.fetch_req && bus.ld_req) begin
      if (starveHit) ldGnt = 1'b1;
      else           fetchGnt = 1'b1;
    end else begin
      fetchGnt = bus.fetch_req;
      ldGnt    = bus.ld_req;
    end
  end

  assign bus.fetch_gnt = fetchGnt;
  assign bus.ld_gnt    = ldGnt;

  // A misaligned fetch is still granted but never touches the RAM.
  assign bus.mem_en    = ldGnt | (fetchGnt & fetchAligned);
  assign bus.mem_we    = ldGnt & bus.ld_we;
  assign bus.mem_idx   = ldGnt ? bus.ld_addr[IDX_HI:2] : bus.fetch_addr[IDX_HI:2];
  assign bus.mem_wdata = bus.ld_wdata;

  always_comb begin
    starveCntD = starveCnt_q;
    ownerD     = OWN_NONE;
    if (ldGnt) begin
      starveCntD = '0;
    end else if (bus.ld_req && fetchGnt && !starveHit) begin
      starveCntD = starveCnt_q + CNT_W'(1);
    end
    if (fetchGnt) begin
      ownerD = fetchAligned ? OWN_FETCH : OWN_FETCH_ERR;
    end else if (ldGnt && !bus.ld_we) begin
      ownerD = OWN_LOAD_RD;
    end
  end

  // Reset drops whatever response is in flight by clearing the owner along with the valids.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      owner_q       <= OWN_NONE;
      starveCnt_q   <= '0;
      fetchRvalid_q <= 1'b0;
      fetchErr_q    <= 1'b0;
      ldRvalid_q    <= 1'b0;
      fetchHold_q   <= '0;
      ldHold_q      <= '0;
    end else begin
      owner_q       <= ownerD;
      starveCnt_q   <= starveCntD;
      fetchRvalid_q <= (ownerD == OWN_FETCH) || (ownerD == OWN_FETCH_ERR);
      fetchErr_q    <= (ownerD == OWN_FETCH_ERR);
      ldRvalid_q    <= (ownerD == OWN_LOAD_RD);
      case (owner_q)
        OWN_FETCH:     fetchHold_q <= bus.mem_rdata;
        OWN_FETCH_ERR: fetchHold_q <= '0;
        OWN_LOAD_RD:   ldHold_q    <= bus.mem_rdata;
        default:       ;
      endcase
    end
  end

  // RAM data is only valid in the response cycle, so it is forwarded then and held afterwards.
  always_comb begin
    bus.fetch_rdata = fetchHold_q;
    bus.ld_rdata    = ldHold_q;
    case (owner_q)
      OWN_FETCH:     bus.fetch_rdata = bus.mem_rdata;
      OWN_FETCH_ERR: bus.fetch_rdata = '0;
      OWN_LOAD_RD:   bus.ld_rdata    = bus.mem_rdata;
      default:       ;
    endcase
  end

  assign bus.fetch_rvalid = fetchRvalid_q;
  assign bus.fetch_err    = fetchErr_q;
  assign bus.ld_rvalid    = ldRvalid_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboarded bench for imem_arbiter: a behavioural RAM plus a shadow copy of its contents
// that predicts every fetch and loader read response.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic boot_mode;
  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_exp_t;

  fetch_exp_t  fetchQ[$];
  logic [31:0] ldQ[$];
  logic [31:0] ram[64];
  logic [31:0] shadow[64];

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .boot_mode_i(boot_mode),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_idx];
    end
  end

  // Response side of the scoreboard: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      compared++;
      if (bus.fetch_gnt && bus.ld_gnt) begin
        mismatched++;
        $display("[TB] FAIL gnt_exclusive: got fetch_gnt=1 ld_gnt=1, expected at most one");
      end
      if (bus.fetch_rvalid) begin
        fetch_exp_t e;
        compared++;
        if (fetchQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL fetch_unexpected: got rvalid with rdata=%h, expected no response", bus.fetch_rdata);
        end else begin
          e = fetchQ.pop_front();
          if (bus.fetch_rdata !== e.data || bus.fetch_err !== e.err) begin
            mismatched++;
            $display("[TB] FAIL fetch_resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                     bus.fetch_rdata, bus.fetch_err, e.data, e.err);
          end
        end
      end
      if (bus.ld_rvalid) begin
        logic [31:0] d;
        compared++;
        if (ldQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL ld_unexpected: got rvalid with rdata=%h, expected no response", bus.ld_rdata);
        end else begin
          d = ldQ.pop_front();
          if (bus.ld_rdata !== d) begin
            mismatched++;
            $display("[TB] FAIL ld_resp: got rdata=%h, expected %h", bus.ld_rdata, d);
          end
        end
      end
    end
  end

  task automatic idleInputs();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_req     = 1'b0;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_wdata   = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    boot_mode = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    compared++;
    if (bus.fetch_rvalid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_valids: got fetch_rvalid=%b fetch_err=%b ld_rvalid=%b, expected 0 0 0",
               bus.fetch_rvalid, bus.fetch_err, bus.ld_rvalid);
    end
    compared++;
    if (bus.fetch_rdata !== 32'h0 || bus.ld_rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_rdata: got fetch=%h ld=%h, expected 0 0", bus.fetch_rdata, bus.ld_rdata);
    end
    compared++;
    if (bus.mem_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mem_en: got %b, expected 0", bus.mem_en);
    end
    nextCycle();
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    logic [31:0] words[2];
    words[0] = 32'h8C010004;
    words[1] = 32'h00221820;
    boot_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 8'h04;
      bus.ld_req     = 1'b1;
      bus.ld_we      = 1'b1;
      bus.ld_addr    = 8'(i * 4);
      bus.ld_wdata   = words[i];
      @(negedge clk);
      compared++;
      if (bus.ld_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0 || bus.mem_we !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL load_write: got ld_gnt=%b fetch_gnt=%b mem_we=%b, expected 1 0 1",
                 bus.ld_gnt, bus.fetch_gnt, bus.mem_we);
      end
      shadow[i] = words[i];
    end
    nextCycle();
    idleInputs();
    boot_mode      = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h04;
    @(negedge clk);
    compared++;
    if (bus.fetch_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_idx !== 6'd1) begin
      mismatched++;
      $display("[TB] FAIL load_fetch_gnt: got gnt=%b mem_en=%b idx=%0d, expected 1 1 1",
               bus.fetch_gnt, bus.mem_en, bus.mem_idx);
    end
    fetchQ.push_back('{data: 32'h00221820, err: 1'b0});
    nextCycle();
    idleInputs();
    @(negedge clk);
    compared++;
    if (bus.fetch_rvalid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_fetch_rvalid: got %b, expected 1", bus.fetch_rvalid);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      idleInputs();
      if (i < 3) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'(i * 4);
      end
      @(negedge clk);
      if (i < 3) begin
        compared++;
        if (bus.fetch_gnt !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL stream_gnt%0d: got %b, expected 1", i, bus.fetch_gnt);
        end
        fetchQ.push_back('{data: shadow[i], err: 1'b0});
      end
      if (i > 0) begin
        compared++;
        if (bus.fetch_rvalid !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL stream_rvalid%0d: got %b, expected 1", i, bus.fetch_rvalid);
        end
      end
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 6; i++) begin
      logic expF;
      nextCycle();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 8'h08;
      bus.ld_req     = 1'b1;
      bus.ld_we      = 1'b0;
      bus.ld_addr    = 8'h04;
      expF = (i != 4);
      @(negedge clk);
      compared++;
      if (bus.fetch_gnt !== expF || bus.ld_gnt !== !expF) begin
        mismatched++;
        $display("[TB] FAIL starve_cycle%0d: got fetch_gnt=%b ld_gnt=%b, expected %b %b",
                 i, bus.fetch_gnt, bus.ld_gnt, expF, !expF);
      end
      if (expF) fetchQ.push_back('{data: shadow[2], err: 1'b0});
      else      ldQ.push_back(shadow[1]);
      if (i == 5) begin
        compared++;
        if (bus.ld_rvalid !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL starve_ld_rvalid: got %b, expected 1", bus.ld_rvalid);
        end
      end
    end
    nextCycle();
    idleInputs();
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    nextCycle();
    idleInputs();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h06;
    @(negedge clk);
    compared++;
    if (bus.fetch_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misaligned_gnt: got gnt=%b mem_en=%b mem_we=%b, expected 1 0 0",
               bus.fetch_gnt, bus.mem_en, bus.mem_we);
    end
    fetchQ.push_back('{data: 32'h0, err: 1'b1});
    nextCycle();
    idleInputs();
    @(negedge clk);
    compared++;
    if (bus.fetch_rvalid !== 1'b1 || bus.fetch_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misaligned_resp: got rvalid=%b err=%b, expected 1 1", bus.fetch_rvalid, bus.fetch_err);
    end
    nextCycle();
    @(negedge clk);
    compared++;
    if (bus.fetch_rvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rvalid_pulse_width: got %b, expected 0", bus.fetch_rvalid);
    end
  endtask

  task automatic test_boot_block();
    boot_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 8'h0C;
      @(negedge clk);
      compared++;
      if (bus.fetch_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL boot_block%0d: got gnt=%b mem_en=%b, expected 0 0", i, bus.fetch_gnt, bus.mem_en);
      end
    end
    nextCycle();
    boot_mode = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.fetch_gnt !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL boot_release_gnt: got %b, expected 1", bus.fetch_gnt);
    end
    fetchQ.push_back('{data: shadow[3], err: 1'b0});
    nextCycle();
    idleInputs();
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    // Build the starvation count up to 2 so the reset clearing it is visible afterwards.
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 8'h00;
      bus.ld_req     = 1'b1;
      bus.ld_we      = 1'b0;
      bus.ld_addr    = 8'h04;
      @(negedge clk);
      compared++;
      if (bus.fetch_gnt !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL midop_pre%0d: got fetch_gnt=%b, expected 1", i, bus.fetch_gnt);
      end
      fetchQ.push_back('{data: shadow[0], err: 1'b0});
    end
    nextCycle();
    bus.ld_req     = 1'b0;
    bus.fetch_addr = 8'h04;
    @(negedge clk);
    compared++;
    if (bus.fetch_gnt !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midop_gnt: got %b, expected 1", bus.fetch_gnt);
    end
    nextCycle();
    reset_n = 1'b0;
    idleInputs();
    @(negedge clk);
    compared++;
    if (bus.fetch_rvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midop_in_reset: got fetch_rvalid=%b, expected 0", bus.fetch_rvalid);
    end
    nextCycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nextCycle();
      @(negedge clk);
      compared++;
      if (bus.fetch_rvalid !== 1'b0 || bus.fetch_rdata !== 32'h0 || bus.ld_rvalid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midop_after%0d: got rvalid=%b rdata=%h ld_rvalid=%b, expected 0 0 0",
                 i, bus.fetch_rvalid, bus.fetch_rdata, bus.ld_rvalid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      logic expF;
      nextCycle();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 8'h00;
      bus.ld_req     = 1'b1;
      bus.ld_we      = 1'b0;
      bus.ld_addr    = 8'h04;
      expF = (i != 4);
      @(negedge clk);
      compared++;
      if (bus.fetch_gnt !== expF || bus.ld_gnt !== !expF) begin
        mismatched++;
        $display("[TB] FAIL midop_starve%0d: got fetch_gnt=%b ld_gnt=%b, expected %b %b",
                 i, bus.fetch_gnt, bus.ld_gnt, expF, !expF);
      end
      if (expF) fetchQ.push_back('{data: shadow[0], err: 1'b0});
      else      ldQ.push_back(shadow[1]);
    end
    nextCycle();
    idleInputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]    = 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    bus.mem_rdata = '0;
    test_reset();
    test_load();
    test_streaming();
    test_starvation();
    test_misaligned();
    test_boot_block();
    test_reset_midop();
    compared++;
    if (fetchQ.size() != 0 || ldQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d fetch and %0d loader responses outstanding, expected 0 0",
               fetchQ.size(), ldQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
